pc_gen: RTL

- Parametrised next-PC generator with its own state: holds the fetch PC register and the decode-stage PC (id_pc). Resolves the branch, jump, jal and jalr redirects of the instruction in decode, using delay-slot semantics.
- Adds behaviour beyond the combinational next-PC mux it replaces: operand comparison, fetch back-pressure, buffering of a pending redirect, exception entry with an EPC register, and eret.
- Sits between the hazard unit and the instruction memory, and feeds fetch and the CP0/exception logic.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_gen_br_cmp.sv | 40 ++++
 rtl/pc_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared encodings and defaults for the next-PC generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GEZ  = 3'd3,
        BR_GTZ  = 3'd4,
        BR_LEZ  = 3'd5,
        BR_LTZ  = 3'd6
    } br_type_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] c_def_reset_pc = 32'h0000_3000;
    localparam logic [31:0] c_def_exc_vec  = 32'h0000_4180;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_gen_br_cmp.sv
`default_nettype none
// ============================================================================
// Module      : br_cmp
// Description : Signed branch-condition evaluation for the decode-stage branch.
// Revision    : 1.0 - initial release
// ============================================================================
module br_cmp
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            taken
);

    logic w_eq;
    logic w_neg;
    logic w_zero;

    assign w_eq   = (rs_val == rt_val);
    assign w_neg  = rs_val[XLEN-1];
    assign w_zero = ~|rs_val;

    always_comb begin
        taken = 1'b0;
        case (br_type_t'(br_type))
            BR_EQ:   taken = w_eq;
            BR_NE:   taken = ~w_eq;
            BR_GEZ:  taken = ~w_neg;
            BR_GTZ:  taken = ~w_neg & ~w_zero;
            BR_LEZ:  taken = w_neg | w_zero;
            BR_LTZ:  taken = w_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule : br_cmp
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch/decode PC state with delay-slot redirects, fetch
//               back-pressure buffering, exception entry and eret.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_def_reset_pc),
    parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(c_def_exc_vec)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_ready,
    input  logic            id_valid_i,
    input  logic [2:0]      br_type,
    input  logic            jump,
    input  logic            jal,
    input  logic            jalr,
    input  logic [25:0]     target,
    input  logic [15:0]     imm16,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            exc_req,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            eret,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] link_o,
    output logic [XLEN-1:0] epc_o,
    output logic            flush_o,
    output logic            addr_err_o
);

    localparam logic [XLEN-1:0] c_four  = XLEN'(4);
    localparam logic [XLEN-1:0] c_eight = XLEN'(8);

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_pend_tgt;

    logic            w_taken;
    logic            w_misaligned;
    logic            w_redir;
    logic            w_advance;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_j_tgt;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_pc_next;
    logic            w_pc_en;
    logic            w_id_en;
    logic            w_pend_en;

    br_cmp #(
        .XLEN    (XLEN)
    ) u_br_cmp (
        .br_type (br_type),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .taken   (w_taken)
    );

    // Branch offset is the word offset sign-extended to XLEN bits.
    assign w_br_tgt = r_id_pc + c_four + XLEN'($signed({imm16, 2'b00}));
    assign w_j_tgt  = XLEN'({r_id_pc[XLEN-1:XLEN-4], target, 2'b00});
    assign w_tgt    = jalr ? rs_val : ((jump | jal) ? w_j_tgt : w_br_tgt);

    // A misaligned jalr must not redirect; the exception path takes over.
    assign w_misaligned = id_valid_i & jalr & (|rs_val[1:0]);
    assign w_redir      = id_valid_i & (jump | jal | (jalr & ~w_misaligned) | w_taken);
    assign w_advance    = ~stall & if_ready;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pc_en      = 1'b0;
        w_id_en      = 1'b0;
        w_pend_en    = 1'b0;
        if (exc_req) begin
            w_pc_next    = EXC_VEC;
            w_pc_en      = 1'b1;
            w_state_next = ST_RUN;
        end else if (eret) begin
            w_pc_next    = r_epc;
            w_pc_en      = 1'b1;
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_advance) begin
                        w_pc_next = w_redir ? w_tgt : (r_pc + c_four);
                        w_pc_en   = 1'b1;
                        w_id_en   = 1'b1;
                    end else if (w_redir && !stall) begin
                        // Decode is moving on without a fetch; keep the target.
                        w_pend_en    = 1'b1;
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_advance) begin
                        w_pc_next    = r_pend_tgt;
                        w_pc_en      = 1'b1;
                        w_id_en      = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_id_pc    <= RESET_PC;
            r_epc      <= '0;
            r_pend_tgt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (w_id_en) begin
                r_id_pc <= r_pc;
            end
            if (exc_req) begin
                r_epc      <= exc_pc;
                r_pend_tgt <= '0;
            end else if (w_pend_en) begin
                r_pend_tgt <= w_tgt;
            end
        end
    end

    assign pc_o       = r_pc;
    assign id_pc_o    = r_id_pc;
    assign epc_o      = r_epc;
    assign link_o     = r_id_pc + c_eight;
    assign flush_o    = exc_req | eret;
    assign addr_err_o = w_misaligned & ~stall & (r_state == ST_RUN);

endmodule : pc_gen
`default_nettype wire
